// File: rtl/ls_mem_responder.sv
// Memory-side responder for the load/store queue: serialises one word/half/byte
// request at a time into byte accesses on an 8-bit synchronous RAM bus.
module ls_mem_responder #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h30000)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_ena,
   input  logic                  in_iswrite,
   input  logic [1:0]            in_size,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0] in_write_data,
   output logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_read_data,
   output logic                  out_busy,
   output logic [ADDR_WIDTH-1:0] out_ram_addr,
   output logic                  out_ram_wr,
   output logic [7:0]            out_ram_dout,
   input  logic [7:0]            in_ram_din,
   input  logic                  in_io_buffer_full
);

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [1:0]            size_q, size_d;
   logic [DATA_WIDTH-1:0] res_q, res_d;
   logic                  ready_q, ready_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  busy_q, busy_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic                  ram_wr_q, ram_wr_d;
   logic [7:0]            ram_dout_q, ram_dout_d;

   logic [2:0]            nbytes;
   logic [1:0]            rd_idx;
   logic [1:0]            wr_idx;
   logic                  io_stall;

   assign nbytes   = (size_q == 2'd0) ? 3'd1 : (size_q == 2'd1) ? 3'd2 : 3'd4;
   assign rd_idx   = 2'(cnt_q - 3'd1);
   assign wr_idx   = cnt_q[1:0];
   assign io_stall = (addr_q >= IO_BASE) && in_io_buffer_full;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      size_d     = size_q;
      res_d      = res_q;
      ready_d    = 1'b0;
      rdata_d    = '0;
      busy_d     = busy_q;
      ram_addr_d = '0;
      ram_wr_d   = 1'b0;
      ram_dout_d = '0;

      unique case (state_q)
         IDLE: begin
            if (in_ena) begin
               addr_d     = in_addr;
               data_d     = in_write_data;
               size_d     = in_size;
               res_d      = '0;
               busy_d     = 1'b1;
               ram_addr_d = in_addr;
               cnt_d      = 3'd1;
               if (in_iswrite) begin
                  state_d = WRITE;
                  // Stall check uses the incoming address: nothing is latched yet.
                  if ((in_addr >= IO_BASE) && in_io_buffer_full) begin
                     cnt_d = 3'd0;
                  end else begin
                     ram_wr_d   = 1'b1;
                     ram_dout_d = in_write_data[7:0];
                  end
               end else begin
                  state_d = READ;
               end
            end
         end

         READ: begin
            res_d[{rd_idx, 3'b000} +: 8] = in_ram_din;
            if (cnt_q >= nbytes) begin
               ready_d = 1'b1;
               rdata_d = res_d;
               busy_d  = 1'b0;
               cnt_d   = 3'd0;
               state_d = IDLE;
            end else begin
               ram_addr_d = addr_q + ADDR_WIDTH'(cnt_q);
               cnt_d      = cnt_q + 3'd1;
            end
         end

         WRITE: begin
            if (cnt_q >= nbytes) begin
               ready_d = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = 3'd0;
               state_d = IDLE;
            end else begin
               ram_addr_d = addr_q + ADDR_WIDTH'(cnt_q);
               if (!io_stall) begin
                  ram_wr_d   = 1'b1;
                  ram_dout_d = data_q[{wr_idx, 3'b000} +: 8];
                  cnt_d      = cnt_q + 3'd1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         size_q     <= '0;
         res_q      <= '0;
         ready_q    <= 1'b0;
         rdata_q    <= '0;
         busy_q     <= 1'b0;
         ram_addr_q <= '0;
         ram_wr_q   <= 1'b0;
         ram_dout_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         size_q     <= size_d;
         res_q      <= res_d;
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
         busy_q     <= busy_d;
         ram_addr_q <= ram_addr_d;
         ram_wr_q   <= ram_wr_d;
         ram_dout_q <= ram_dout_d;
      end
   end

   assign out_ready     = ready_q;
   assign out_read_data = rdata_q;
   assign out_busy      = busy_q;
   assign out_ram_addr  = ram_addr_q;
   assign out_ram_wr    = ram_wr_q;
   assign out_ram_dout  = ram_dout_q;

endmodule

// File: tb/tb_ls_mem_responder.sv
// Directed bench for ls_mem_responder: byte-wide RAM model plus a scoreboard of
// expected load results checked whenever out_ready pulses.
module tb_ls_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_ena = 1'b0;
   logic        in_iswrite = 1'b0;
   logic [1:0]  in_size = 2'd0;
   logic [31:0] in_addr = '0;
   logic [31:0] in_write_data = '0;
   logic        out_ready;
   logic [31:0] out_read_data;
   logic        out_busy;
   logic [31:0] out_ram_addr;
   logic        out_ram_wr;
   logic [7:0]  out_ram_dout;
   logic [7:0]  in_ram_din;
   logic        in_io_buffer_full = 1'b0;

   logic [7:0]  mem [0:4095];
   int unsigned nwr = 0;
   logic        poke = 1'b0;
   logic [11:0] poke_a = '0;
   logic [7:0]  poke_d = '0;

   logic [31:0] sb [$];
   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned wr_base;
   logic        prev_ready = 1'b0;

   ls_mem_responder #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .IO_BASE(32'h30000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_ena(in_ena),
      .in_iswrite(in_iswrite),
      .in_size(in_size),
      .in_addr(in_addr),
      .in_write_data(in_write_data),
      .out_ready(out_ready),
      .out_read_data(out_read_data),
      .out_busy(out_busy),
      .out_ram_addr(out_ram_addr),
      .out_ram_wr(out_ram_wr),
      .out_ram_dout(out_ram_dout),
      .in_ram_din(in_ram_din),
      .in_io_buffer_full(in_io_buffer_full)
   );

   always #5 clk = ~clk;

   // Data for the registered address is visible in the following cycle.
   assign in_ram_din = mem[out_ram_addr[11:0]];

   always @(posedge clk) begin
      if (poke) begin
         mem[poke_a] <= poke_d;
      end else if (out_ram_wr) begin
         mem[out_ram_addr[11:0]] <= out_ram_dout;
         nwr <= nwr + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke_mem(input logic [11:0] a, input logic [7:0] d);
      poke_a = a;
      poke_d = d;
      poke   = 1'b1;
      tick();
      poke   = 1'b0;
   endtask

   task automatic request(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d);
      in_ena        = 1'b1;
      in_iswrite    = wr;
      in_size       = sz;
      in_addr       = a;
      in_write_data = d;
   endtask

   always @(negedge clk) begin
      if (rst && out_ready) begin
         check("ready_one_cycle", 32'(prev_ready), 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_ready", 32'd1, 32'd0);
         end else begin
            check("read_data", out_read_data, sb.pop_front());
         end
      end
      prev_ready = out_ready;
   end

   initial begin
      // Reset state and RAM preload.
      poke_mem(12'h100, 8'h78);
      poke_mem(12'h101, 8'h56);
      poke_mem(12'h102, 8'h34);
      poke_mem(12'h103, 8'h12);
      poke_mem(12'h205, 8'hF0);
      poke_mem(12'h012, 8'h5A);
      poke_mem(12'h302, 8'hEE);
      poke_mem(12'h303, 8'hEE);
      check("rst_ready", 32'(out_ready), 32'd0);
      check("rst_busy", 32'(out_busy), 32'd0);
      check("rst_wr", 32'(out_ram_wr), 32'd0);
      check("rst_addr", out_ram_addr, 32'd0);
      check("rst_dout", 32'(out_ram_dout), 32'd0);
      check("rst_rdata", out_read_data, 32'd0);
      rst = 1'b1;
      tick();

      // Word load with an ignored request presented while busy.
      request(1'b0, 2'd2, 32'h100, 32'h0);
      sb.push_back(32'h12345678);
      tick();
      check("wl_busy", 32'(out_busy), 32'd1);
      check("wl_addr0", out_ram_addr, 32'h100);
      check("wl_wr0", 32'(out_ram_wr), 32'd0);
      request(1'b1, 2'd2, 32'h300, 32'hCAFEF00D);
      wr_base = nwr;
      tick();
      check("wl_addr1", out_ram_addr, 32'h101);
      tick();
      check("wl_addr2", out_ram_addr, 32'h102);
      tick();
      check("wl_addr3", out_ram_addr, 32'h103);
      check("wl_ready_early", 32'(out_ready), 32'd0);
      in_ena = 1'b0;
      tick();
      check("wl_ready", 32'(out_ready), 32'd1);
      check("wl_busy_done", 32'(out_busy), 32'd0);
      check("wl_addr_idle", out_ram_addr, 32'd0);
      check("wl_no_writes", nwr, wr_base);

      // Byte load accepted back-to-back in the out_ready cycle.
      request(1'b0, 2'd0, 32'h205, 32'h0);
      sb.push_back(32'h000000F0);
      tick();
      check("bl_ready_cleared", 32'(out_ready), 32'd0);
      check("bl_busy", 32'(out_busy), 32'd1);
      check("bl_addr", out_ram_addr, 32'h205);
      in_ena = 1'b0;
      tick();
      check("bl_ready", 32'(out_ready), 32'd1);
      check("bl_busy_done", 32'(out_busy), 32'd0);

      // Half store, again back-to-back.
      request(1'b1, 2'd1, 32'h10, 32'hDEADBEEF);
      sb.push_back(32'h0);
      wr_base = nwr;
      tick();
      check("hs_wr0", 32'(out_ram_wr), 32'd1);
      check("hs_addr0", out_ram_addr, 32'h10);
      check("hs_dout0", 32'(out_ram_dout), 32'hEF);
      in_ena = 1'b0;
      tick();
      check("hs_wr1", 32'(out_ram_wr), 32'd1);
      check("hs_addr1", out_ram_addr, 32'h11);
      check("hs_dout1", 32'(out_ram_dout), 32'hBE);
      tick();
      check("hs_wr_off", 32'(out_ram_wr), 32'd0);
      check("hs_ready", 32'(out_ready), 32'd1);
      check("hs_mem10", 32'(mem[12'h010]), 32'hEF);
      check("hs_mem11", 32'(mem[12'h011]), 32'hBE);
      check("hs_mem12", 32'(mem[12'h012]), 32'h5A);
      check("hs_nwr", nwr, wr_base + 2);
      tick();

      // I/O stall on a byte store.
      in_io_buffer_full = 1'b1;
      request(1'b1, 2'd0, 32'h30000, 32'h000000A5);
      sb.push_back(32'h0);
      wr_base = nwr;
      tick();
      check("io_busy", 32'(out_busy), 32'd1);
      check("io_stall0", 32'(out_ram_wr), 32'd0);
      in_ena = 1'b0;
      tick();
      check("io_stall1", 32'(out_ram_wr), 32'd0);
      tick();
      check("io_stall2", 32'(out_ram_wr), 32'd0);
      in_io_buffer_full = 1'b0;
      tick();
      check("io_wr", 32'(out_ram_wr), 32'd1);
      check("io_addr", out_ram_addr, 32'h30000);
      check("io_dout", 32'(out_ram_dout), 32'hA5);
      check("io_ready_early", 32'(out_ready), 32'd0);
      tick();
      check("io_wr_off", 32'(out_ram_wr), 32'd0);
      check("io_ready", 32'(out_ready), 32'd1);
      check("io_nwr", nwr, wr_base + 1);
      check("io_mem", 32'(mem[12'h000]), 32'hA5);
      tick();

      // Reset during a word store after two bytes have been written.
      request(1'b1, 2'd2, 32'h300, 32'h11223344);
      tick();
      check("rs_dout0", 32'(out_ram_dout), 32'h44);
      in_ena = 1'b0;
      tick();
      check("rs_dout1", 32'(out_ram_dout), 32'h33);
      tick();
      rst = 1'b0;
      #1;
      check("rs_ready", 32'(out_ready), 32'd0);
      check("rs_busy", 32'(out_busy), 32'd0);
      check("rs_wr", 32'(out_ram_wr), 32'd0);
      check("rs_addr", out_ram_addr, 32'd0);
      check("rs_dout", 32'(out_ram_dout), 32'd0);
      tick();
      tick();
      check("rs_mem300", 32'(mem[12'h300]), 32'h44);
      check("rs_mem301", 32'(mem[12'h301]), 32'h33);
      check("rs_mem302", 32'(mem[12'h302]), 32'hEE);
      check("rs_mem303", 32'(mem[12'h303]), 32'hEE);
      rst = 1'b1;
      tick();

      // Next request after reset completes normally.
      request(1'b0, 2'd2, 32'h300, 32'h0);
      sb.push_back(32'hEEEE3344);
      tick();
      in_ena = 1'b0;
      tick();
      tick();
      tick();
      check("pr_ready_early", 32'(out_ready), 32'd0);
      tick();
      check("pr_ready", 32'(out_ready), 32'd1);
      tick();
      tick();
      check("sb_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ls_mem_responder.md
Name: ls_mem_responder

Overview:
- Memory-side responder for the load/store queue's single-outstanding request interface.
- Accepts one word, half or byte read/write request at a time.
- Serialises each request into byte accesses on the 8-bit synchronous RAM bus.
- Returns one `out_ready` pulse with assembled read data; sign extension stays with the requester.

Parameters:
ADDR_WIDTH, 32, request and RAM address width
DATA_WIDTH, 32, request data width
IO_BASE, 32'h30000, writes at or above this address are I/O and obey in_io_buffer_full

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_ena  input  1  request strobe, sampled only in IDLE
in_iswrite  input  1  1=store, 0=load
in_size  input  2  0=byte, 1=half, 2=word; 3 is treated as word
in_addr  input  ADDR_WIDTH  base byte address
in_write_data  input  DATA_WIDTH  store data; byte k = bits [8k+7:8k]
out_ready  output  1  one-cycle completion pulse, for loads and stores
out_read_data  output  DATA_WIDTH  zero-extended load result, valid while out_ready=1
out_busy  output  1  high from the accepting edge until the edge that raises out_ready
out_ram_addr  output  ADDR_WIDTH  RAM byte address
out_ram_wr  output  1  RAM write enable
out_ram_dout  output  8  RAM write byte
in_ram_din  input  8  RAM read byte; one-cycle latency after its address
in_io_buffer_full  input  1  I/O sink cannot take a byte this cycle

Behaviour:
- All outputs are registered.
- Reset (rst low, asynchronous): state=IDLE; every output is 0; byte counter and latched request are cleared.
- Reset mid-operation aborts the access. No out_ready is produced. Any bytes already written stay written.
- N = number of bytes: 1, 2 or 4 from in_size.
- States: IDLE, READ, WRITE.
- IDLE:
  - out_ram_wr=0, out_ram_addr=0.
  - On an edge with in_ena=1: latch addr, data, size and iswrite; set out_busy=1; go to READ or WRITE.
  - On the accepting edge, byte 0 is driven immediately: out_ram_addr<=in_addr, plus out_ram_wr<=1 and out_ram_dout<=byte0 for a store.
- READ, with k counting bytes issued:
  - Each edge captures in_ram_din into result byte (k-1).
  - If k<N, the same edge drives out_ram_addr<=base+k.
  - On the edge capturing byte N-1: out_ready<=1, out_read_data<=assembled value with upper bytes 0, out_busy<=0, state<=IDLE.
  - Word load: out_ready is high in the cycle after the 4th edge following acceptance. Byte load: after the 1st edge.
- WRITE:
  - Each edge drives the next byte: out_ram_addr<=base+k, out_ram_dout<=byte k, out_ram_wr<=1.
  - After byte N-1 is driven, the next edge sets out_ram_wr<=0, out_ready<=1 and state<=IDLE.
  - out_read_data is 0 for stores.
- I/O stall:
  - Applies when the latched address is >= IO_BASE and in_io_buffer_full=1 at an edge that would drive a write byte, including the accepting edge.
  - That edge drives out_ram_wr<=0 and does not advance k.
  - The byte is retried on each following edge until in_io_buffer_full=0.
  - Loads ignore in_io_buffer_full.
- out_ready:
  - Exactly one cycle wide.
  - Cleared on the next edge unconditionally.
- Request timing:
  - in_ena while not in IDLE is ignored; the requester guarantees a single outstanding request.
  - A new request may be accepted on the edge that ends the out_ready cycle (back-to-back, zero bubble).
- Address increment is modulo 2^ADDR_WIDTH; the base address is not required to be aligned.
- Byte order is little-endian.

Test Plan:
- Word load: RAM[0x100..0x103]=78,56,34,12; pulse in_ena, size=2, addr=0x100 -> out_ram_addr sequence 0x100..0x103; out_ready one cycle after the 4th post-accept edge; out_read_data=0x12345678.
- Byte load with top bit set: RAM[0x205]=0xF0, size=0 -> out_read_data=0x000000F0 and out_ready after 1 edge.
- Half store: addr=0x10, data=0xDEADBEEF, size=1 -> writes EF@0x10 and BE@0x11 only; RAM[0x12] unchanged; out_ready=1 with out_read_data=0.
- I/O stall: byte store to 0x30000 with in_io_buffer_full=1 for 3 cycles then 0 -> out_ram_wr stays 0 for 3 cycles, then exactly one write of the byte, then out_ready.
- Busy/back-to-back: second in_ena during a word load is ignored (no extra RAM traffic). A request presented during the out_ready cycle starts on the following edge.
- Reset mid-operation: assert rst low after 2 bytes of a word store -> all outputs 0 immediately; no out_ready; only 2 bytes modified; the next request completes normally.
